// File: rtl/dvp_frame_gen.sv
// dvp_frame_gen: camera-side DVP source producing OV2640-style Y8 frame timing and test patterns
module dvp_frame_gen #(
  parameter int H_ACT    = 640,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 3,
  parameter int V_BP     = 17,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       PIXCLK,
  input  logic       irst_n,
  input  logic       en,
  input  logic [1:0] pat_sel,
  output logic       VSYNC,
  output logic       HREF,
  output logic [9:0] PIXDATA,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);
  localparam int L = H_ACT + H_BLANK;
  localparam int V_MAX1 = VS_LINES > V_BP ? VS_LINES : V_BP;
  localparam int V_MAX2 = V_ACT > V_FP ? V_ACT : V_FP;
  localparam int V_MAX = V_MAX1 > V_MAX2 ? V_MAX1 : V_MAX2;
  localparam int HW = $clog2(L);
  localparam int VW = $clog2(V_MAX + 1);
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACT, S_VFP} state_t;
  state_t state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vlast;
  logic [1:0] pat_q, pat_d;
  logic [7:0] flat_q, flat_d, frame_cnt_q, frame_cnt_d, x8, y8, y_val;
  logic vsync_q, vsync_d, href_q, href_d, done_q, done_d, line_end;
  logic [9:0] pix_q, pix_d;
  // Timing FSM: steps one line at a time; pattern and flat value are frozen at each frame start
  always_comb begin
    state_d = state_q;
    vcnt_d = vcnt_q;
    pat_d = pat_q;
    flat_d = flat_q;
    line_end = hcnt_q == HW'(L - 1);
    vlast = state_q == S_VSYNC ? VW'(VS_LINES - 1) : state_q == S_VBP ? VW'(V_BP - 1) :
            state_q == S_ACT ? VW'(V_ACT - 1) : VW'(V_FP - 1);
    hcnt_d = (state_q == S_IDLE || line_end) ? '0 : hcnt_q + HW'(1);
    if (state_q == S_IDLE) begin
      if (en) begin
        state_d = S_VSYNC;
        pat_d = pat_sel;
        flat_d = frame_cnt_q;
      end
    end else if (line_end) begin
      vcnt_d = vcnt_q == vlast ? '0 : vcnt_q + VW'(1);
      if (vcnt_q == vlast) begin
        case (state_q)
          S_VSYNC: state_d = S_VBP;
          S_VBP:   state_d = S_ACT;
          S_ACT:   state_d = S_VFP;
          default: begin
            state_d = en ? S_VSYNC : S_IDLE;
            pat_d = en ? pat_sel : pat_q;
            flat_d = frame_cnt_q;
          end
        endcase
      end
    end
  end
  // Outputs are derived from the next timing state so the registered pins line up with it
  always_comb begin
    x8 = 8'(hcnt_d);
    y8 = 8'(vcnt_d);
    y_val = pat_d == 2'd0 ? x8 : pat_d == 2'd1 ? y8 : pat_d == 2'd2 ? {8{x8[3] ^ y8[3]}} : flat_q;
    y_val = pat_d == 2'd3 ? flat_d : y_val;
    vsync_d = state_d == S_VSYNC ? VS_POL : ~VS_POL;
    href_d = state_d == S_ACT && hcnt_d < HW'(H_ACT);
    pix_d = href_d ? {y_val, 2'b00} : '0;
    done_d = state_d == S_VFP && hcnt_d == HW'(L - 1) && vcnt_d == VW'(V_FP - 1);
    frame_cnt_d = frame_cnt_q + {7'd0, done_d};
  end
  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge PIXCLK or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
      hcnt_q <= '0;
      vcnt_q <= '0;
      pat_q <= '0;
      flat_q <= '0;
      frame_cnt_q <= '0;
      vsync_q <= ~VS_POL;
      href_q <= 1'b0;
      pix_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      pat_q <= pat_d;
      flat_q <= flat_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q <= vsync_d;
      href_q <= href_d;
      pix_q <= pix_d;
      done_q <= done_d;
    end
  end
  assign VSYNC = vsync_q;
  assign HREF = href_q;
  assign PIXDATA = pix_q;
  assign frame_done = done_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_dvp_frame_gen.sv
// tb_dvp_frame_gen: scoreboard bench for the DVP frame generator with reduced frame geometry
module tb_dvp_frame_gen;
  localparam int H_ACT = 260, H_BLANK = 4, VS_LINES = 2, V_BP = 3, V_ACT = 16, V_FP = 2;
  localparam int L = H_ACT + H_BLANK;
  localparam int FRAME = L * (VS_LINES + V_BP + V_ACT + V_FP);
  logic PIXCLK = 0, rst_n = 0, en = 0, rst2_n = 0, en2 = 0;
  logic [1:0] pat = 0;
  logic VSYNC, HREF, frame_done, VSYNC2, HREF2, frame_done2;
  logic [9:0] PIXDATA, PIXDATA2;
  logic [7:0] frame_cnt, frame_cnt2;
  int asserts = 0, fails = 0, cyc = 0;
  int pix_q[$];
  int fr_q[$];
  bit b2b = 0, tiny_done = 0;
  int prev_vs, prev_href, vs_fall, href_len, href_cnt, first_href, last_done;

  dvp_frame_gen #(.H_ACT(H_ACT), .H_BLANK(H_BLANK), .VS_LINES(VS_LINES), .V_BP(V_BP),
                  .V_ACT(V_ACT), .V_FP(V_FP), .VS_POL(1'b0)) dut (
    .PIXCLK(PIXCLK), .irst_n(rst_n), .en(en), .pat_sel(pat), .VSYNC(VSYNC), .HREF(HREF),
    .PIXDATA(PIXDATA), .frame_done(frame_done), .frame_cnt(frame_cnt));

  dvp_frame_gen #(.H_ACT(1), .H_BLANK(2), .VS_LINES(1), .V_BP(1), .V_ACT(1), .V_FP(1),
                  .VS_POL(1'b0)) tiny (
    .PIXCLK(PIXCLK), .irst_n(rst2_n), .en(en2), .pat_sel(2'd0), .VSYNC(VSYNC2), .HREF(HREF2),
    .PIXDATA(PIXDATA2), .frame_done(frame_done2), .frame_cnt(frame_cnt2));

  always #5 PIXCLK = ~PIXCLK;
  always @(posedge PIXCLK) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input int p, input int c);
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++)
        pix_q.push_back((p == 0 ? (x & 255) : p == 1 ? (y & 255) :
                         p == 2 ? ((((x >> 3) ^ (y >> 3)) & 1) != 0 ? 255 : 0) : (c & 255)) << 2);
    fr_q.push_back((c + 1) & 255);
  endtask

  task automatic wait_done();
    for (int i = 0; i < FRAME + 200; i++) begin
      @(negedge PIXCLK);
      if (frame_done) return;
    end
    check("frame_done_timeout", 0, 1);
  endtask

  task automatic start_frame(input int p, input int c);
    @(negedge PIXCLK);
    pat = 2'(p);
    en = 1;
    push_frame(p, c);
    @(negedge PIXCLK);
    en = 0;
  endtask

  initial begin
    forever begin
      @(negedge PIXCLK);
      if (!rst_n) begin
        prev_vs = 1; prev_href = 0; href_len = 0; href_cnt = 0; first_href = 0; last_done = -1;
      end else begin
        if (prev_vs == 1 && !VSYNC) begin vs_fall = cyc; href_cnt = 0; first_href = 1; end
        if (prev_vs == 0 && VSYNC) check("vsync_len", cyc - vs_fall, VS_LINES * L);
        if (HREF) begin
          if (prev_href == 0) begin
            href_len = 0;
            if (first_href == 1) begin
              check("first_href", cyc - vs_fall, (VS_LINES + V_BP) * L);
              first_href = 0;
            end
          end
          href_len++;
          if (pix_q.size() == 0) check("pix_unexpected", int'(PIXDATA), -1);
          else check("pix", int'(PIXDATA), pix_q.pop_front());
        end else begin
          if (prev_href == 1) begin check("href_len", href_len, H_ACT); href_cnt++; end
          check("pix_idle", int'(PIXDATA), 0);
        end
        if (frame_done) begin
          if (fr_q.size() == 0) check("frame_done_unexpected", int'(frame_cnt), -1);
          else check("frame_cnt", int'(frame_cnt), fr_q.pop_front());
          check("href_lines", href_cnt, V_ACT);
          if (b2b && last_done >= 0) check("frame_period", cyc - last_done, FRAME);
          last_done = cyc;
        end
        prev_vs = int'(VSYNC);
        prev_href = int'(HREF);
      end
    end
  end

  initial begin
    repeat (3) @(negedge PIXCLK);
    rst2_n = 1;
    en2 = 1;
    for (int i = 1; i <= 256; i++) begin
      for (int k = 0; k < 30; k++) begin
        @(negedge PIXCLK);
        if (frame_done2) break;
      end
      check("wrap_cnt", frame_done2 ? int'(frame_cnt2) : -1, i & 255);
    end
    en2 = 0;
    tiny_done = 1;
  end

  initial begin
    repeat (3) @(negedge PIXCLK);
    check("rst_vsync", int'(VSYNC), 1);
    check("rst_href", int'(HREF), 0);
    check("rst_pix", int'(PIXDATA), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_cnt", int'(frame_cnt), 0);
    rst_n = 1;
    start_frame(0, 0);
    wait_done();
    repeat (3) @(negedge PIXCLK);
    check("t1_idle_vsync", int'(VSYNC), 1);
    check("t1_pix_left", pix_q.size(), 0);
    start_frame(2, 1);
    wait_done();
    start_frame(0, 2);
    repeat ((VS_LINES + V_BP + 10) * L + 100) @(negedge PIXCLK);
    check("t4_mid_href", int'(HREF), 1);
    pat = 2'd2;
    wait_done();
    repeat (700) @(negedge PIXCLK);
    check("t4_idle_vsync", int'(VSYNC), 1);
    check("t4_idle_href", int'(HREF), 0);
    check("t4_pix_left", pix_q.size(), 0);
    check("t4_fr_left", fr_q.size(), 0);
    @(negedge PIXCLK);
    rst_n = 0;
    repeat (2) @(negedge PIXCLK);
    rst_n = 1;
    b2b = 1;
    pat = 2'd3;
    en = 1;
    push_frame(3, 0);
    push_frame(3, 1);
    push_frame(3, 2);
    wait_done();
    wait_done();
    repeat (10) @(negedge PIXCLK);
    en = 0;
    wait_done();
    b2b = 0;
    check("t3_fr_left", fr_q.size(), 0);
    start_frame(1, 3);
    repeat ((VS_LINES + V_BP + 10) * L + 200) @(negedge PIXCLK);
    #2 rst_n = 0;
    pix_q.delete();
    fr_q.delete();
    #1;
    check("t5_vsync", int'(VSYNC), 1);
    check("t5_href", int'(HREF), 0);
    check("t5_pix", int'(PIXDATA), 0);
    check("t5_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge PIXCLK);
    rst_n = 1;
    pat = 2'd1;
    en = 1;
    push_frame(1, 0);
    @(negedge PIXCLK);
    en = 0;
    wait_done();
    check("t5_pix_left", pix_q.size(), 0);
    for (int i = 0; i < 10000 && !tiny_done; i++) @(negedge PIXCLK);
    check("tiny_done", int'(tiny_done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
